// File: rtl/ysyx_23060236_tlb.sv
// Fully-associative TLB: combinational VPN->PPN lookup, single-cycle fill,
// round-robin victim replacement once every entry is valid.
module ysyx_23060236_tlb #(
    parameter int ENTRIES = 8,
    parameter int VPN_W   = 20,
    parameter int PPN_W   = 20
) (
    input  logic             clock,
    input  logic             reset,
    input  logic             flush,
    input  logic [VPN_W-1:0] tlb_araddr,
    output logic             tlb_hit,
    output logic [PPN_W-1:0] tlb_rdata,
    input  logic             tlb_wvalid,
    input  logic [VPN_W-1:0] tlb_awaddr,
    input  logic [PPN_W-1:0] tlb_wdata
);

    localparam int IW = (ENTRIES > 1) ? $clog2(ENTRIES) : 1;

    logic [ENTRIES-1:0] valid;
    logic [VPN_W-1:0]   vpn [ENTRIES];
    logic [PPN_W-1:0]   ppn [ENTRIES];
    logic [IW-1:0]      vptr;

    logic               w_match;
    logic [IW-1:0]      w_match_idx;
    logic               w_free;
    logic [IW-1:0]      w_free_idx;
    logic [IW-1:0]      w_idx;
    logic               w_en;

    // At most one entry can match, so OR-ing the masked PPNs is a clean mux.
    always_comb begin
        tlb_hit   = 1'b0;
        tlb_rdata = '0;
        for (int i = 0; i < ENTRIES; i++) begin
            if (valid[i] && vpn[i] == tlb_araddr) begin
                tlb_hit   = 1'b1;
                tlb_rdata = tlb_rdata | ppn[i];
            end
        end
    end

    always_comb begin
        w_match     = 1'b0;
        w_match_idx = '0;
        w_free      = 1'b0;
        w_free_idx  = '0;
        // Descending scan so the lowest-index free slot is the one kept.
        for (int i = ENTRIES - 1; i >= 0; i--) begin
            if (valid[i] && vpn[i] == tlb_awaddr) begin
                w_match     = 1'b1;
                w_match_idx = IW'(i);
            end
            if (!valid[i]) begin
                w_free     = 1'b1;
                w_free_idx = IW'(i);
            end
        end
    end

    always_comb begin
        w_idx = vptr;
        priority case (1'b1)
            w_match: w_idx = w_match_idx;
            w_free:  w_idx = w_free_idx;
            default: w_idx = vptr;
        endcase
    end

    assign w_en = tlb_wvalid && !flush;

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            valid <= '0;
            vptr  <= '0;
        end else if (flush) begin
            valid <= '0;
            vptr  <= '0;
        end else if (w_en) begin
            valid[w_idx] <= 1'b1;
            if (!w_match && !w_free) begin
                vptr <= vptr + 1'b1;
            end
        end
    end

    always_ff @(posedge clock) begin
        if (w_en) begin
            vpn[w_idx] <= tlb_awaddr;
            ppn[w_idx] <= tlb_wdata;
        end
    end

endmodule

// File: tb/tb_ysyx_23060236_tlb.sv
// Directed bench for ysyx_23060236_tlb: lookup, fill priority, replacement,
// flush precedence, no-bypass and asynchronous reset.
module tb_ysyx_23060236_tlb;

    logic        clock;
    logic        reset;
    logic        flush;
    logic [19:0] tlb_araddr;
    logic        tlb_hit;
    logic [19:0] tlb_rdata;
    logic        tlb_wvalid;
    logic [19:0] tlb_awaddr;
    logic [19:0] tlb_wdata;

    int checks   = 0;
    int failures = 0;

    ysyx_23060236_tlb #(.ENTRIES(8), .VPN_W(20), .PPN_W(20)) dut (
        .clock      (clock),
        .reset      (reset),
        .flush      (flush),
        .tlb_araddr (tlb_araddr),
        .tlb_hit    (tlb_hit),
        .tlb_rdata  (tlb_rdata),
        .tlb_wvalid (tlb_wvalid),
        .tlb_awaddr (tlb_awaddr),
        .tlb_wdata  (tlb_wdata)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    task automatic chk(input string tag, input logic [31:0] obs,
                       input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic look(input string tag, input logic [19:0] v,
                        input logic eh, input logic [19:0] ep);
        tlb_araddr = v;
        #1;
        chk({tag, "_hit"}, {31'd0, tlb_hit}, {31'd0, eh});
        chk({tag, "_ppn"}, {12'd0, tlb_rdata}, {12'd0, ep});
    endtask

    // Called at a negedge; returns at the next negedge with wvalid low.
    task automatic fill(input logic [19:0] v, input logic [19:0] p);
        tlb_wvalid = 1'b1;
        tlb_awaddr = v;
        tlb_wdata  = p;
        @(negedge clock);
        tlb_wvalid = 1'b0;
    endtask

    initial begin
        reset      = 1'b0;
        flush      = 1'b0;
        tlb_araddr = 20'h0;
        tlb_wvalid = 1'b0;
        tlb_awaddr = 20'h0;
        tlb_wdata  = 20'h0;
        repeat (2) @(negedge clock);
        look("in_reset", 20'h12345, 1'b0, 20'h0);
        @(negedge clock);
        reset = 1'b1;
        @(negedge clock);

        look("post_reset", 20'h12345, 1'b0, 20'h0);
        look("post_reset2", 20'h00000, 1'b0, 20'h0);

        fill(20'h12345, 20'h80001);
        look("fill_hit", 20'h12345, 1'b1, 20'h80001);
        look("fill_neighbor", 20'h12346, 1'b0, 20'h0);

        fill(20'h12345, 20'h80002);
        look("overwrite", 20'h12345, 1'b1, 20'h80002);

        flush = 1'b1;
        @(negedge clock);
        flush = 1'b0;
        look("flush1", 20'h12345, 1'b0, 20'h0);

        for (int i = 0; i < 10; i++) begin
            fill(20'(i), 20'h100 + 20'(i));
        end
        look("repl_0", 20'h0, 1'b0, 20'h0);
        look("repl_1", 20'h1, 1'b0, 20'h0);
        look("repl_8", 20'h8, 1'b1, 20'h108);
        look("repl_9", 20'h9, 1'b1, 20'h109);
        look("repl_2", 20'h2, 1'b1, 20'h102);
        fill(20'hA, 20'h10A);
        look("vptr2_victim", 20'h2, 1'b0, 20'h0);
        look("vptr2_keep3", 20'h3, 1'b1, 20'h103);
        look("vptr2_new", 20'hA, 1'b1, 20'h10A);

        flush = 1'b1;
        fill(20'hABCDE, 20'h55555);
        flush = 1'b0;
        look("flush_fill", 20'hABCDE, 1'b0, 20'h0);
        look("flush_old3", 20'h3, 1'b0, 20'h0);
        look("flush_old8", 20'h8, 1'b0, 20'h0);

        // Back-to-back fills with wvalid held; ninth shows vptr restarted at 0.
        for (int i = 0; i < 9; i++) begin
            fill(20'h20 + 20'(i), 20'h200 + 20'(i));
        end
        look("vptr0_victim", 20'h20, 1'b0, 20'h0);
        look("vptr0_keep", 20'h21, 1'b1, 20'h201);
        look("vptr0_new", 20'h28, 1'b1, 20'h208);

        tlb_araddr = 20'h00010;
        tlb_wvalid = 1'b1;
        tlb_awaddr = 20'h00010;
        tlb_wdata  = 20'h0ABCD;
        #1;
        chk("nobypass_hit", {31'd0, tlb_hit}, 32'd0);
        @(posedge clock);
        #1;
        tlb_wvalid = 1'b0;
        chk("bypass_next_hit", {31'd0, tlb_hit}, 32'd1);
        chk("bypass_next_ppn", {12'd0, tlb_rdata}, 32'h0ABCD);

        #2;
        reset = 1'b0;
        #1;
        chk("async_rst_hit", {31'd0, tlb_hit}, 32'd0);
        chk("async_rst_ppn", {12'd0, tlb_rdata}, 32'd0);
        @(negedge clock);
        reset = 1'b1;
        @(negedge clock);
        look("after_rst", 20'h00010, 1'b0, 20'h0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
